// File: rtl/mem_request_unit.sv
// Load/store request unit: buffers up to two pipeline commands and drives the
// memory system's request interface, with a stall watchdog that aborts stuck accesses.
module mem_request_unit #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] DataIn,
  input  logic              Stall,
  input  logic [DATA_W-1:0] DataOut
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [7:0] Limit = 8'(STALL_LIMIT);

  // The in-flight command stays at the FIFO head until it completes or aborts.
  logic              fifo_write_q [2];
  logic [ADDR_W-1:0] fifo_addr_q  [2];
  logic [DATA_W-1:0] fifo_wdata_q [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  state_e            state_q, state_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic              push, pop;
  logic              load, load_from_fifo, load_idx;
  logic              ld_write;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;

  assign req_ready = (count_q != 2'd2);
  assign push      = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= req_write;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  always_comb begin
    ld_write = load_from_fifo ? fifo_write_q[load_idx] : req_write;
    ld_addr  = load_from_fifo ? fifo_addr_q[load_idx]  : req_addr;
    ld_wdata = load_from_fifo ? fifo_wdata_q[load_idx] : req_wdata;
  end

  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    addr_d         = addr_q;
    din_d          = din_q;
    rsp_valid_d    = 1'b0;
    rsp_write_d    = 1'b0;
    rsp_rdata_d    = '0;
    rsp_error_d    = 1'b0;
    pop            = 1'b0;
    load           = 1'b0;
    load_from_fifo = 1'b0;
    load_idx       = rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (count_q != 2'd0) begin
          load           = 1'b1;
          load_from_fifo = 1'b1;
        end else if (push) begin
          // Empty FIFO: issue straight from the pipeline in the accept cycle.
          load = 1'b1;
        end
      end
      StAccess: begin
        if (!Stall) begin
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_write_d = mem_write_q;
          rsp_rdata_d = mem_write_q ? '0 : DataOut;
          stall_cnt_d = '0;
          if (count_q == 2'd2) begin
            load           = 1'b1;
            load_from_fifo = 1'b1;
            load_idx       = ~rd_ptr_q;
          end else if (push) begin
            load = 1'b1;
          end else begin
            state_d     = StIdle;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
          end
        end else if (stall_cnt_q + 8'd1 == Limit) begin
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_write_d = mem_write_q;
          rsp_error_d = 1'b1;
          stall_cnt_d = '0;
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d     = StAccess;
      mem_read_d  = ~ld_write;
      mem_write_d = ld_write;
      addr_d      = ld_addr;
      din_d       = ld_wdata;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign mem_address = addr_q;
  assign DataIn      = din_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign busy        = (count_q != 2'd0) | (state_q == StAccess);

endmodule

// File: doc/mem_request_unit.md
# mem_request_unit

CPU-side initiator for the data memory system: accepts load/store commands from the pipeline MEM stage over a valid/ready handshake, buffers up to two of them, and drives the memory system's MemRead/MemWrite/mem_address/DataIn request interface. It holds each request stable while Stall is high and returns load data or store completion on a one-cycle response strobe. A stall watchdog aborts any access that stalls beyond a limit.

## Interface
- ADDR_W, 12, request address width
- DATA_W, 32, data width
- STALL_LIMIT, 255, consecutive Stall cycles before abort (1..255, 8-bit counter)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  pipeline command valid
- req_ready  output  1  unit can accept a command (FIFO not full)
- req_write  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  command address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  one-cycle completion strobe
- rsp_write  output  1  completed command was a store
- rsp_rdata  output  DATA_W  load data (0 for stores and errors)
- rsp_error  output  1  completion was a watchdog abort
- busy  output  1  FIFO non-empty or access in progress
- MemRead  output  1  read request to memory system
- MemWrite  output  1  write request to memory system
- mem_address  output  ADDR_W  request address
- DataIn  output  DATA_W  write data
- Stall  input  1  memory system not done; hold request
- DataOut  input  DATA_W  read data, valid in the cycle Stall is low

## Operation
- Command FIFO: 2 entries {write, addr, wdata}; push on req_valid & req_ready; req_ready = (count < 2), no push when full even if a pop occurs the same cycle.
- FSM states: IDLE, ACCESS.
- IDLE: MemRead = MemWrite = 0. If FIFO non-empty at an edge → ACCESS with head loaded into registered outputs (MemRead = !write, MemWrite = write, mem_address, DataIn).
- ACCESS: outputs held exactly stable while Stall = 1. Completion = ACCESS & Stall = 0 at an edge: pop head, capture DataOut (loads) into rsp_rdata, pulse rsp_valid next cycle, reset stall counter. If another entry remains (including one pushed at this edge), load it and stay in ACCESS; else → IDLE.
- Watchdog: 8-bit counter increments each ACCESS cycle with Stall = 1. When it reaches STALL_LIMIT: pop head, rsp_valid = 1, rsp_error = 1, rsp_rdata = 0, deassert request, → IDLE for one cycle before issuing the next entry.
- Only one of MemRead/MemWrite is ever high.
- Stores return rsp_write = 1, rsp_rdata = 0.
- Reset (asynchronous, mid-operation included): FIFO emptied, FSM → IDLE, counter = 0. Every output is 0 except req_ready = 1. In-flight access is dropped with no response.

## Timing
- Command accepted at edge E0 → request visible on memory interface after E0.
- Hit (Stall = 0): completes at E1; rsp_valid high for cycle after E1. Total 2 edges.
- Each stall cycle adds 1 cycle latency.
- Back-to-back: next request visible after completion edge with no bubble. Sustained hit throughput is 1 access/cycle.
- After an abort, the next request is visible one cycle later than in the back-to-back case.
- rsp_* are registered and valid only while rsp_valid = 1; otherwise 0.
- busy = (FIFO count ≠ 0) | (state = ACCESS).

## Test plan
- Single load addr 0x010, Stall = 0, DataOut = 0xDEADBEEF → MemRead high 1 cycle, rsp_valid next cycle with rsp_rdata = 0xDEADBEEF, rsp_write = 0.
- Load 0x020 with Stall high 3 cycles → MemRead/mem_address held 4 cycles, single rsp_valid after Stall falls, latency 5 edges.
- Store 0x030 = 0x12345678 then load 0x030 on consecutive cycles, hits → MemWrite then MemRead in adjacent cycles, two rsp_valid pulses, second returns DataOut.
- Three commands while Stall held high → req_ready low after 2 accepted; it rises the cycle after the first completes.
- STALL_LIMIT = 4, Stall stuck high → abort after 4 stall cycles, rsp_error = 1, rsp_rdata = 0, MemRead low, next queued command issued after one IDLE cycle.
- rst asserted mid-stall with 2 queued → outputs 0 immediately (req_ready = 1), no rsp_valid, busy = 0 after release.
